cdc_handshake_tx: RTL and testbench

Source-domain sender of a 4-phase req/ack clock-domain-crossing link: accepts one WIDTH-bit word from a ready/valid producer, holds it stable on `xfer_data`, and runs a full req/ack handshake with a destination-domain receiver. The receiver samples `xfer_data` after synchronizing `xfer_req`. This block is the transmitting counterpart to the team's 2-flop `sync` receiver. It brings the returning `xfer_ack` back into the `clk` domain with its own synchronizer chain.

---
 rtl/cdc_handshake_tx.sv | 101 ++++++++++
 tb/tb_cdc_handshake_tx.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_handshake_tx.sv
// cdc_handshake_tx: source-domain sender of a 4-phase req/ack CDC link.
// Takes one word from a ready/valid producer, holds it on xfer_data and runs a
// full req/ack handshake with the destination. xfer_ack is resynchronized into
// clk through a SYNC_STAGES-deep flop chain (SYNC_STAGES must be >= 2).
module cdc_handshake_tx #(
   parameter int unsigned WIDTH       = 4,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             xfer_req,
   output logic [WIDTH-1:0] xfer_data,
   input  logic             xfer_ack,
   output logic             busy,
   output logic             done
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] REQ     = 2'd1;
   localparam logic [1:0] RELEASE = 2'd2;

   logic [SYNC_STAGES-1:0] ack_sync;
   logic                   ack_s;
   logic [1:0]             state;
   logic [1:0]             state_next;
   logic                   req_next;
   logic [WIDTH-1:0]       data_next;
   logic                   done_next;
   logic                   accept;

   // Resynchronize the destination ack; only the last flop is ever used.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ack_sync <= '0;
      end else begin
         ack_sync <= {ack_sync[SYNC_STAGES-2:0], xfer_ack};
      end
   end

   assign ack_s = ack_sync[SYNC_STAGES-1];

   // A still-high ack in IDLE is stale: it blocks accepts but moves nothing.
   always_comb begin
      in_ready = (state == IDLE) && !ack_s;
      accept   = in_ready && in_valid;
      busy     = (state != IDLE);
   end

   // Next-state logic for the handshake and the payload holding register.
   always_comb begin
      state_next = state;
      req_next   = xfer_req;
      data_next  = xfer_data;
      done_next  = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               data_next  = in_data;
               req_next   = 1'b1;
               state_next = REQ;
            end
         end
         REQ: begin
            if (ack_s) begin
               req_next   = 1'b0;
               state_next = RELEASE;
            end
         end
         RELEASE: begin
            // Return to IDLE only once the ack has been seen low again.
            if (!ack_s) begin
               state_next = IDLE;
               done_next  = 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
            req_next   = 1'b0;
         end
      endcase
   end

   // State, request, payload and done flops; xfer_req/xfer_data leave from here.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         xfer_req  <= 1'b0;
         xfer_data <= '0;
         done      <= 1'b0;
      end else begin
         state     <= state_next;
         xfer_req  <= req_next;
         xfer_data <= data_next;
         done      <= done_next;
      end
   end

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// tb_cdc_handshake_tx: scoreboard bench for cdc_handshake_tx. The producer and
// destination models push expected words and event cycles; a monitor pops and
// compares whenever the DUT raises/drops xfer_req or pulses done.
module tb_cdc_handshake_tx;

   localparam int S = 2;

   logic       clk;
   logic       reset;
   logic       in_valid;
   logic [3:0] in_data;
   logic       in_ready;
   logic       xfer_req;
   logic [3:0] xfer_data;
   logic       xfer_ack;
   logic       busy;
   logic       done;

   // 0: loopback, 1: slow destination model, 2: manual ack
   int         mode;
   logic       dest_ack;
   int         d1, d2;
   int         cyc;
   int         ready_at;
   int         total, bad;
   logic [3:0] cur_word;
   logic       prev_req;
   int         data_q[$];
   int         fall_q[$];
   int         done_q[$];

   assign xfer_ack = (mode == 0) ? xfer_req : dest_ack;

   cdc_handshake_tx #(
      .WIDTH       (4),
      .SYNC_STAGES (S)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .xfer_req  (xfer_req),
      .xfer_data (xfer_data),
      .xfer_ack  (xfer_ack),
      .busy      (busy),
      .done      (done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc = cyc + 1;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Present word w at a negedge and hold it until accepted; then optionally
   // drive garbage with in_valid high for garb cycles while the DUT is busy.
   task automatic send(input logic [3:0] w, input int garb, input logic [3:0] gdata);
      int  p, acc, ex;
      bit  ok;
      in_valid = 1'b1;
      in_data  = w;
      p  = cyc;
      ok = 1'b0;
      for (int n = 0; n < 300; n++) begin
         if (in_ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) begin
         check("accept_timeout", 0, 1);
         in_valid = 1'b0;
         return;
      end
      acc = cyc + 1;
      ex  = (p + 1 > ready_at + 1) ? p + 1 : ready_at + 1;
      check("accept_cycle", acc, ex);
      data_q.push_back(int'(w));
      if (mode == 0) begin
         fall_q.push_back(acc + S + 1);
         done_q.push_back(acc + 2 * S + 2);
         ready_at = acc + 2 * S + 2;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = 4'($urandom);
      @(negedge clk);
      repeat (garb) begin
         in_valid = 1'b1;
         in_data  = gdata;
         @(negedge clk);
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (busy === 1'b0) return;
      end
      check("idle_timeout", 0, 1);
   endtask

   // Slow destination: raise ack d1 cycles after req, drop it d2 cycles after req falls.
   initial begin
      int n;
      forever begin
         @(negedge clk);
         if (mode == 1 && !reset && xfer_req === 1'b1) begin
            repeat (d1) @(negedge clk);
            dest_ack = 1'b1;
            fall_q.push_back(cyc + S + 1);
            n = 0;
            while (xfer_req === 1'b1 && n < 300) begin
               @(negedge clk);
               n++;
            end
            repeat (d2) @(negedge clk);
            dest_ack = 1'b0;
            done_q.push_back(cyc + S + 1);
            ready_at = cyc + S + 1;
         end
      end
   end

   // Monitor: compares DUT outputs against the queued expectations.
   initial begin
      int e;
      prev_req = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev_req = xfer_req;
            continue;
         end
         if (xfer_req && !prev_req) begin
            if (data_q.size() == 0) begin
               check("req_rise_unexpected", 1, 0);
            end else begin
               e = data_q.pop_front();
               check("xfer_data_at_req", 32'(xfer_data), e);
               cur_word = 4'(e);
            end
         end else begin
            check("xfer_data_stable", 32'(xfer_data), 32'(cur_word));
         end
         if (!xfer_req && prev_req) begin
            if (fall_q.size() == 0) check("req_fall_unexpected", 1, 0);
            else check("req_fall_cycle", cyc, fall_q.pop_front());
         end
         if (busy) check("in_ready_while_busy", in_ready, 0);
         if (done) begin
            check("busy_at_done", busy, 0);
            if (done_q.size() == 0) check("done_unexpected", 1, 0);
            else check("done_cycle", cyc, done_q.pop_front());
         end
         prev_req = xfer_req;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int f, m, gap;
      total    = 0;
      bad      = 0;
      mode     = 0;
      dest_ack = 1'b0;
      d1       = 0;
      d2       = 0;
      ready_at = 0;
      cur_word = 4'h0;
      reset    = 1'b1;
      in_valid = 1'b0;
      in_data  = 4'h0;

      // Power-on reset values
      repeat (3) @(negedge clk);
      check("rst_req", xfer_req, 0);
      check("rst_data", 32'(xfer_data), 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      reset = 1'b0;
      #1;
      check("rst_ready", in_ready, 1);
      ready_at = cyc;
      @(negedge clk);

      // Single loopback transfer, per-cycle profile after the accept edge E0
      send(4'hA, 0, 4'h0);
      check("lb_data", 32'(xfer_data), 32'hA);
      for (int k = 0; k < 8; k++) begin
         check("lb_req", xfer_req, (k < S + 1) ? 1 : 0);
         check("lb_done", done, (k == 2 * S + 2) ? 1 : 0);
         check("lb_ready", in_ready, (k >= 2 * S + 2) ? 1 : 0);
         check("lb_busy", busy, (k < 2 * S + 2) ? 1 : 0);
         @(negedge clk);
      end

      // Back-to-back words, then busy backpressure with 4'hF garbage
      send(4'h3, 0, 4'h0);
      send(4'hC, 0, 4'h0);
      send(4'h6, 3, 4'hF);
      wait_idle();

      // Slow destination
      mode = 1;
      d1   = 10;
      d2   = 5;
      send(4'h9, 0, 4'h0);
      wait_idle();

      // Randomized mix of loopback and slow destinations
      for (int i = 0; i < 30; i++) begin
         m = $urandom_range(0, 1);
         if (m != mode) begin
            wait_idle();
            mode = m;
         end
         if (mode == 1) begin
            d1 = $urandom_range(0, 6);
            d2 = $urandom_range(0, 6);
         end
         gap = $urandom_range(0, 2);
         repeat (gap) @(negedge clk);
         send(4'($urandom), $urandom_range(0, 3), 4'($urandom));
         if (mode == 1) wait_idle();
      end
      wait_idle();

      // Stale ack in IDLE blocks accepts until it has drained through the chain
      mode     = 2;
      dest_ack = 1'b1;
      repeat (S + 1) @(negedge clk);
      check("stale_ready", in_ready, 0);
      in_valid = 1'b1;
      in_data  = 4'h5;
      repeat (4) begin
         @(negedge clk);
         check("stale_ready_hold", in_ready, 0);
         check("stale_busy", busy, 0);
      end
      f        = cyc;
      dest_ack = 1'b0;
      ready_at = f + S;
      send(4'h5, 0, 4'h0);
      repeat (2) @(negedge clk);
      check("stuck_req", xfer_req, 1);

      // Reset mid-transfer: outputs clear without a clock edge
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check("mid_rst_req", xfer_req, 0);
      check("mid_rst_data", 32'(xfer_data), 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_done", done, 0);
      cur_word = 4'h0;
      in_valid = 1'b0;
      mode     = 0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("mid_rst_ready", in_ready, 1);
      ready_at = cyc;
      @(negedge clk);
      send(4'hE, 0, 4'h0);
      wait_idle();
      repeat (2) @(negedge clk);

      check("data_q_empty", data_q.size(), 0);
      check("fall_q_empty", fall_q.size(), 0);
      check("done_q_empty", done_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
